// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the configurable UART: FSM state encoding,
// error-flag bit positions and the minimum usable bit period.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  localparam int ERR_OVR = 2;
  localparam int ERR_PAR = 1;
  localparam int ERR_FRM = 0;

  localparam int MIN_PRESC = 4;

endpackage

// File: rtl/uart_cfg_fifo.sv
// First-word fall-through FIFO with a registered head word.
// When the FIFO drains, the head register keeps its last value.
module uart_cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_wr, do_rd;

  assign full       = (count_q == DEPTH[AW:0]);
  assign empty      = (count_q == '0);
  assign level      = count_q;
  assign rd_data    = head_q;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  // A write into a full FIFO only goes ahead when a read frees a slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_nxt;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The head comes from the incoming word when it becomes the only entry.
    if (do_wr && (empty || (count_q == 1 && do_rd))) begin
      head_d = wr_data;
    end else if (do_rd && count_q > 1) begin
      head_d = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// UART with runtime bit period, optional parity, configurable stop bits,
// TX/RX FIFOs and sticky error flags.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_AW    = 4,
  parameter int PRESC_W    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [PRESC_W-1:0]   prescaler,
  output logic                 TX,
  input  logic                 RX,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wren,
  output logic [DATA_BITS-1:0] data_out,
  input  logic                 rden,
  output logic                 tx_full,
  output logic                 rx_empty,
  output logic [FIFO_AW+1:0]   tx_fill_lvl,
  output logic [FIFO_AW:0]     rx_fill_lvl,
  output logic [2:0]           err_flags,
  input  logic                 err_clr
);

  logic [PRESC_W-1:0] presc_eff;
  assign presc_eff = (prescaler < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : prescaler;

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_fifo_data;
  logic                 tx_fifo_empty;
  logic [FIFO_AW:0]     tx_level;
  logic                 tx_pop;

  uart_cfg_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (CLK),
    .rst_n   (rst_n),
    .wr_en   (wren),
    .wr_data (data_in),
    .rd_en   (tx_pop),
    .rd_data (tx_fifo_data),
    .full    (tx_full),
    .empty   (tx_fifo_empty),
    .level   (tx_level)
  );

  uart_state_e          tx_state_q;
  logic                 tx_q;
  logic [PRESC_W-1:0]   tx_p_q;
  logic [PRESC_W-1:0]   tx_cnt_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_par_q;
  logic                 tx_bit_end;
  logic                 tx_last_stop;

  assign tx_bit_end   = (tx_cnt_q == tx_p_q - 1'b1);
  assign tx_last_stop = (tx_state_q == ST_STOP) && tx_bit_end && (tx_bit_q == 4'(STOP_BITS - 1));
  // Popping on the final stop cycle lets the next start bit follow with no gap.
  assign tx_pop       = !tx_fifo_empty && ((tx_state_q == ST_IDLE) || tx_last_stop);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_q       <= 1'b1;
      tx_p_q     <= PRESC_W'(MIN_PRESC);
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
    end else if (tx_pop) begin
      tx_state_q <= ST_START;
      tx_q       <= 1'b0;
      tx_p_q     <= presc_eff;
      tx_cnt_q   <= '0;
      tx_sh_q    <= tx_fifo_data;
      tx_bit_q   <= '0;
      tx_par_q   <= (^tx_fifo_data) ^ (PARITY_ODD != 0);
    end else begin
      case (tx_state_q)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_state_q <= ST_DATA;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'(DATA_BITS - 1)) begin
              tx_bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_state_q <= ST_PARITY;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= ST_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_state_q <= ST_STOP;
            tx_q       <= 1'b1;
            tx_bit_q   <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'(STOP_BITS - 1)) tx_state_q <= ST_IDLE;
            else                               tx_bit_q   <= tx_bit_q + 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_state_q <= ST_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign TX          = tx_q;
  assign tx_fill_lvl = {1'b0, tx_level} + (FIFO_AW + 2)'(tx_state_q != ST_IDLE);

  // ---------------- RX path ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  uart_state_e          rx_state_q;
  logic [PRESC_W-1:0]   rx_p_q;
  logic [PRESC_W-1:0]   rx_cnt_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic [3:0]           rx_bit_q;
  logic                 rx_par_q;
  logic [PRESC_W-1:0]   rx_half;
  logic                 rx_fall;
  logic                 rx_sample;
  logic                 rx_stop_smp;
  logic                 rx_par_ok;
  logic                 rx_push;
  logic                 rx_full;
  logic [2:0]           err_q, err_d, err_new;

  assign rx_half   = {1'b0, rx_p_q[PRESC_W-1:1]};
  assign rx_fall   = rx_prev_q && !rx_s2_q;
  assign rx_sample = (rx_state_q == ST_START) ? (rx_cnt_q == rx_half - 1'b1)
                                              : (rx_cnt_q == rx_p_q - 1'b1);
  assign rx_stop_smp = (rx_state_q == ST_STOP) && rx_sample;
  assign rx_par_ok   = (PARITY_EN == 0) || (rx_par_q == ((^rx_sh_q) ^ (PARITY_ODD != 0)));
  assign rx_push     = rx_stop_smp && rx_s2_q && rx_par_ok;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_p_q     <= PRESC_W'(MIN_PRESC);
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= ST_START;
            rx_p_q     <= presc_eff;
            rx_cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (rx_sample) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_sample) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == 4'(DATA_BITS - 1)) begin
              rx_state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (rx_sample) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_s2_q;
            rx_state_q <= ST_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_sample) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s2_q ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        // A low stop bit may be a break; stay off the line until it rises.
        ST_WAIT_HIGH: if (rx_s2_q) rx_state_q <= ST_IDLE;
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (CLK),
    .rst_n   (rst_n),
    .wr_en   (rx_push),
    .wr_data (rx_sh_q),
    .rd_en   (rden),
    .rd_data (data_out),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_fill_lvl)
  );

  always_comb begin
    err_new          = '0;
    err_new[ERR_FRM] = rx_stop_smp && !rx_s2_q;
    err_new[ERR_PAR] = rx_stop_smp && rx_s2_q && !rx_par_ok;
    err_new[ERR_OVR] = rx_push && rx_full && !rden;
    err_d            = (err_clr ? 3'b000 : err_q) | err_new;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_flags = err_q;

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Parametrised successor of the fixed-rate UART top with its built-in TX/RX FIFOs. Adds:
- a runtime-programmable bit period;
- configurable data width, FIFO depth and stop bits;
- optional parity;
- sticky error reporting (framing, parity, overrun).

It sits between the CPU/peripheral bus and the board serial pins, with byte-stream FIFO interfaces on both directions.

Parameters:
DATA_BITS, 8, frame data bits; legal 5..8; LSB sent first.
FIFO_AW, 4, log2 FIFO depth; each FIFO holds 2**FIFO_AW words.
PRESC_W, 16, width of prescaler input.
PARITY_EN, 0, 1 = parity bit after data.
PARITY_ODD, 0, 1 = odd parity, 0 = even (only when PARITY_EN=1).
STOP_BITS, 1, 1 or 2 stop bits on TX; RX checks the first stop bit only.

Ports:
CLK  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
prescaler  in  PRESC_W  CLK cycles per bit; sampled at each frame start; values <4 treated as 4.
TX  out  1  serial out, idle high.
RX  in  1  serial in, asynchronous.
data_in  in  DATA_BITS  TX write data.
wren  in  1  push data_in into TX FIFO.
data_out  out  DATA_BITS  head of RX FIFO (first-word fall-through).
rden  in  1  pop RX FIFO.
tx_full  out  1  TX FIFO full.
rx_empty  out  1  RX FIFO empty.
tx_fill_lvl  out  FIFO_AW+2  TX FIFO count plus 1 while a frame is shifting.
rx_fill_lvl  out  FIFO_AW+1  RX FIFO count.
err_flags  out  3  sticky flags {overrun, parity_err, framing_err}.
err_clr  in  1  clears all of err_flags.

Behaviour:
- Reset (async, rst_n=0) values: TX=1, tx_full=0, rx_empty=1, fill levels 0, err_flags=0, data_out=0, both FSMs IDLE, FIFOs emptied.
- Reset mid-frame aborts immediately; TX returns high and the partial RX frame is discarded.
- FIFOs:
  - wren while full is ignored. rden while empty is ignored; data_out holds.
  - wren and rden together: both are performed when full; only the write when empty; the level is unchanged otherwise.
  - data_out is valid whenever rx_empty=0.
- TX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - In IDLE with the TX FIFO non-empty: pop the head and latch prescaler in the same cycle; the next cycle TX goes low.
  - Each bit lasts exactly P cycles.
  - STOP lasts STOP_BITS*P cycles.
  - Back-to-back frames: the next START begins the cycle after STOP ends, with no idle gap.
- RX:
  - RX passes through a 2-flop synchroniser; 2 cycles of latency are acceptable.
  - FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: a falling edge of the synchronised RX latches P and enters START.
  - START: sample at P/2 (floor) cycles. A high sample is a false start; return to IDLE with no flag.
  - Each later bit is sampled P cycles after the previous sample.
  - STOP sample low: set framing_err, discard the word, then wait for RX high before IDLE.
  - Parity mismatch: set parity_err and discard the word.
  - Otherwise push the word, in the cycle of the stop sample. If the RX FIFO is full, the word is dropped and overrun is set.
- Error flags:
  - Sticky until err_clr.
  - An err_clr coinciding with a new error leaves that flag set.
- Prescaler:
  - Bit counters are PRESC_W wide.
  - A prescaler change mid-frame does not affect the current frame.

Decomposition:
- Package uart_cfg_pkg:
  - TX/RX state enum;
  - error-flag bit indices (OVR=2, PAR=1, FRM=0);
  - minimum prescaler constant (4).
- One sub-module, uart_cfg_fifo:
  - parametrised width/depth;
  - FWFT;
  - full, empty and fill-level outputs.
  - Instantiated twice.
- TX and RX FSMs stay in the top.

Test Plan:
- P=16, write 0xA5, defaults → TX low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high; tx_fill_lvl reads 1 during the frame and 0 after.
- TX-to-RX loopback, P=8, write 0x00, 0xFF, 0x3C back-to-back → rx_fill_lvl=3; data_out gives 0x00, 0xFF, 0x3C on successive rden; err_flags=0.
- PARITY_EN=1, even parity: drive 0x01 with parity bit 0 → word dropped, err_flags=3'b010; err_clr → 3'b000.
- Drive 0x55 with stop bit low → framing_err set, RX FIFO still empty; RX held low causes no further pushes until it returns high.
- FIFO_AW=4: receive 17 words without rden → rx_fill_lvl=16, overrun set, the first 16 words read back intact.
- RX low pulse of P/4 cycles → no state change and no flags. Then assert rst_n=0 mid-TX-frame → TX=1 immediately and all levels read 0.
